// File: rtl/picoview_pkg.sv
// Shared constants for the picoview sampler capture path and the control-register
// status word that reports the result FIFO state.
package picoview_pkg;

    localparam int RESULT_WIDTH      = 32;
    localparam int RESULT_FIFO_DEPTH = 16;
    localparam int RESULT_FIFO_CW    = $clog2(RESULT_FIFO_DEPTH) + 1;
    localparam int STATUS_W          = 4 + RESULT_FIFO_CW;

    // Status word layout, MSB first: {overflow, underflow, full, empty, count}
    function automatic logic [STATUS_W-1:0] pack_status(
        input logic                      overflow,
        input logic                      underflow,
        input logic                      full,
        input logic                      empty,
        input logic [RESULT_FIFO_CW-1:0] count
    );
        return {overflow, underflow, full, empty, count};
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// One-bit registered rising-edge detector. RESET_VAL=1 suppresses a level that is
// already high when reset releases.
module rising_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) d_q <= RESET_VAL;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/sample_result_fifo.sv
// Capture FIFO for offset-sampler results: one entry per rising edge of result_ready,
// drained word-by-word by register reads, with sticky overflow/underflow and drop count.
module sample_result_fifo
    import picoview_pkg::*;
#(
    parameter int DEPTH      = RESULT_FIFO_DEPTH,
    parameter int WIDTH      = RESULT_WIDTH,
    parameter int DROP_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    result_ready,
    input  logic [WIDTH-1:0]        result,
    input  logic                    clear,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
    output logic                    underflow,
    output logic [DROP_CNT_W-1:0]   drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_req;
    logic             do_push, do_pop, drop, bad_pop;
    logic [CW-1:0]    count_nxt;

    rising_edge_detect #(.RESET_VAL(1'b1)) u_rdy_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (result_ready),
        .rise  (push_req)
    );

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    always_comb begin
        do_push   = push_req && (!full || pop);
        do_pop    = pop && !empty;
        drop      = push_req && full && !pop;
        bad_pop   = pop && empty;
        count_nxt = count;
        if (do_push && !do_pop)      count_nxt = count + CW'(1);
        else if (!do_push && do_pop) count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
            end
            if (bad_pop) underflow <= 1'b1;
        end
    end

    // Storage is not reset; only the write is gated by reset and clear.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && do_push) mem[wr_ptr] <= result;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_sample_result_fifo.sv
// Directed bench for sample_result_fifo: capture, fill/drain, overflow, underflow,
// clear priority, reset suppression and pointer wrap.
module tb_sample_result_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int DCW   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic             clear;
    logic             pop;
    logic [WIDTH-1:0] head_data;
    logic [4:0]       count;
    logic             empty, full, overflow, underflow;
    logic [DCW-1:0]   drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sample_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROP_CNT_W(DCW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result_ready (result_ready),
        .result       (result),
        .clear        (clear),
        .pop          (pop),
        .head_data    (head_data),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow),
        .drop_count   (drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        result       = v;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [31:0] q[$];
    logic [31:0] nv;

    initial begin
        rst_n = 1'b0; result_ready = 1'b0; result = '0; clear = 1'b0; pop = 1'b0;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_head", head_data, 0);
        rst_n = 1'b1;
        tick();

        // level-held result_ready captures once
        result = 32'h0000_1234; result_ready = 1'b1;
        tick();
        chk("cap_count", count, 1);
        chk("cap_head", head_data, 32'h0000_1234);
        chk("cap_empty", empty, 0);
        repeat (4) tick();
        chk("hold_count", count, 1);
        result_ready = 1'b0;
        tick();
        do_pop();
        chk("cap_drained", empty, 1);

        // fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) push(i);
        chk("fill_full", full, 1);
        chk("fill_ovf0", overflow, 0);
        push(32'hDEAD);
        chk("drop_full", full, 1);
        chk("drop_ovf", overflow, 1);
        chk("drop_cnt", drop_count, 1);
        chk("drop_count", count, 16);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain_%0d", i), head_data, i);
            do_pop();
        end
        chk("drain_empty", empty, 1);
        chk("drain_head", head_data, 0);
        chk("drain_ovf_sticky", overflow, 1);
        do_clear();

        // push with pop at occupancy 4
        for (int i = 11; i <= 14; i++) push(i);
        result = 32'hAA; result_ready = 1'b1; pop = 1'b1;
        tick();
        result_ready = 1'b0; pop = 1'b0;
        tick();
        chk("pp_count", count, 4);
        chk("pp_head", head_data, 12);
        for (int i = 12; i <= 14; i++) begin
            chk($sformatf("pp_drain_%0d", i), head_data, i);
            do_pop();
        end
        chk("pp_last", head_data, 32'hAA);
        do_pop();
        chk("pp_empty", empty, 1);

        // underflow, then push+pop on empty
        do_pop();
        chk("udf_flag", underflow, 1);
        chk("udf_count", count, 0);
        result = 32'h55; result_ready = 1'b1; pop = 1'b1;
        tick();
        result_ready = 1'b0; pop = 1'b0;
        chk("udf_pp_count", count, 1);
        chk("udf_pp_head", head_data, 32'h55);
        tick();
        do_clear();

        // clear beats a concurrent push
        for (int i = 0; i < 17; i++) push(32'h100 + i);
        for (int i = 0; i < 8; i++) do_pop();
        chk("pre_clr_count", count, 8);
        chk("pre_clr_ovf", overflow, 1);
        result = 32'h77; result_ready = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_count, 0);
        chk("clr_head", head_data, 0);
        tick();
        chk("clr_no_recap", count, 0);
        result_ready = 1'b0;
        tick();

        // reset with result_ready high: no capture until a fresh edge
        result = 32'h300; result_ready = 1'b1; rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("rstrel_count", count, 0);
        result_ready = 1'b0;
        tick();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("rstrel_cap", count, 1);
        chk("rstrel_head", head_data, 32'h300);
        tick();
        q.push_back(32'h300);

        // pointer wrap with concurrent push/pop
        for (int i = 0; i < 20; i++) begin
            nv = 32'h400 + i;
            result = nv; result_ready = 1'b1; pop = 1'b1;
            tick();
            result_ready = 1'b0; pop = 1'b0;
            q.push_back(nv);
            void'(q.pop_front());
            chk($sformatf("wrap_head_%0d", i), head_data, q[0]);
            chk($sformatf("wrap_count_%0d", i), count, 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
